// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: runs load/output/free rounds of the weight buffer for a job of filter groups.
// Optional PE-stall counter is built when WEIGHT_LOAD_CTRL_PERF_EN is defined.
module weight_load_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned OUT_HOLD = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        mode_in_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  num_groups_i,
  input  logic              abort_i,
  output logic              mem_rd_req_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic              mem_rd_gnt_i,
  input  logic              wb_mem_req_i,
  input  logic              wb_ready_i,
  input  logic              pe_ready_i,
  output logic [1:0]        wb_mode_o,
  output logic              wb_output_filter_o,
  output logic              wb_free_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  groups_left_o,
  output logic [15:0]       stall_cycles_o
);

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned BEAT_W  = 7;
  localparam int unsigned HOLD_W  = $clog2(OUT_HOLD + 1);
  localparam int unsigned STALL_W = 16;

  localparam logic [MODE_W-1:0] MODE1 = 2'd0;
  localparam logic [MODE_W-1:0] MODE3 = 2'd2;
  localparam logic [MODE_W-1:0] MODE4 = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_FULL, S_WAIT_PE, S_OUTPUT, S_FREE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    groups_q, groups_d;
  logic [BEAT_W-1:0]   issued_q, issued_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                of_q, of_d;
  logic                free_q, free_d;
  logic [BEAT_W-1:0]   beats_c;
  logic                req_c;

  // Beats per filter group for the latched mode
  always_comb begin
    unique case (mode_q)
      MODE3:   beats_c = BEAT_W'(20);
      MODE4:   beats_c = BEAT_W'(12);
      default: beats_c = BEAT_W'(88);
    endcase
  end

  assign req_c = (state_q == S_LOAD) && wb_mem_req_i && (issued_q < beats_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE1;
      addr_q   <= '0;
      groups_q <= '0;
      issued_q <= '0;
      hold_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      of_q     <= 1'b0;
      free_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      groups_q <= groups_d;
      issued_q <= issued_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      of_q     <= of_d;
      free_q   <= free_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    groups_d = groups_q;
    issued_d = issued_q;
    hold_d   = hold_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    // A grant is always counted, even in the cycle an abort arrives
    if (req_c && mem_rd_gnt_i) begin
      issued_d = issued_q + BEAT_W'(1);
      addr_d   = addr_q + ADDR_W'(8);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d   = mode_in_i;
          addr_d   = base_addr_i & ~ADDR_W'(7);
          groups_d = num_groups_i;
          issued_d = '0;
          busy_d   = 1'b1;
          state_d  = (num_groups_i == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (issued_d == beats_c) state_d = S_WAIT_FULL;
      end
      S_WAIT_FULL: begin
        if (wb_ready_i) state_d = S_WAIT_PE;
      end
      S_WAIT_PE: begin
        hold_d = '0;
        if (pe_ready_i) state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(OUT_HOLD - 1)) state_d = S_FREE;
      end
      S_FREE: begin
        issued_d = '0;
        if (groups_q <= CNT_W'(1)) begin
          groups_d = '0;
          state_d  = S_DONE;
        end else begin
          groups_d = groups_q - CNT_W'(1);
          state_d  = S_LOAD;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drains through a single free cycle; a job already in DONE just finishes
    if (abort_i) begin
      unique case (state_q)
        S_LOAD, S_WAIT_FULL, S_WAIT_PE, S_OUTPUT: begin
          groups_d = '0;
          state_d  = S_FREE;
        end
        S_FREE: begin
          groups_d = '0;
          state_d  = S_DONE;
        end
        default: ;
      endcase
    end

    of_d   = (state_d == S_OUTPUT);
    free_d = (state_d == S_FREE);
  end

  assign mem_rd_req_o       = req_c;
  assign mem_rd_addr_o      = addr_q;
  assign wb_mode_o          = mode_q;
  assign wb_output_filter_o = of_q;
  assign wb_free_o          = free_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign groups_left_o      = groups_q;

`ifdef WEIGHT_LOAD_CTRL_PERF_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  // Saturating count of cycles spent waiting on the PE array
  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start_i) begin
      stall_d = '0;
    end else if ((state_q == S_WAIT_PE) && !pe_ready_i && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl: randomized jobs scored against a
// transaction-level model (beats per mode, address arithmetic, pulse counts).
module tb_weight_load_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  mode_in_i;
  logic [31:0] base_addr_i;
  logic [7:0]  num_groups_i;
  logic        abort_i;
  logic        mem_rd_req_o;
  logic [31:0] mem_rd_addr_o;
  logic        mem_rd_gnt_i;
  logic        wb_mem_req_i;
  logic        wb_ready_i;
  logic        pe_ready_i;
  logic [1:0]  wb_mode_o;
  logic        wb_output_filter_o;
  logic        wb_free_o;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  groups_left_o;
  logic [15:0] stall_cycles_o;

  weight_load_ctrl #(.ADDR_W(32), .CNT_W(8), .OUT_HOLD(13)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_in_i(mode_in_i),
    .base_addr_i(base_addr_i), .num_groups_i(num_groups_i), .abort_i(abort_i),
    .mem_rd_req_o(mem_rd_req_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_gnt_i(mem_rd_gnt_i),
    .wb_mem_req_i(wb_mem_req_i), .wb_ready_i(wb_ready_i), .pe_ready_i(pe_ready_i),
    .wb_mode_o(wb_mode_o), .wb_output_filter_o(wb_output_filter_o), .wb_free_o(wb_free_o),
    .busy_o(busy_o), .done_o(done_o), .groups_left_o(groups_left_o),
    .stall_cycles_o(stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Job observations collected by run_job
  logic [31:0] gaddr[$];
  int          of_runs[$];
  int n_grant, n_free, n_done, done_cyc, free_cyc, abort_cyc;
  int early_of, req_after_abort, busy_gap, mode_bad, req_cycles, busy_after;
  logic [7:0]  groups_at_free, groups_after_start;
  logic [15:0] stall_end;
  logic        busy_at_done;
  bit          timeout;

  function automatic int beats_of(input logic [1:0] m);
    if (m == 2'd2) return 20;
    if (m == 2'd3) return 12;
    return 88;
  endfunction

  function automatic int exp_stall(input int ng, input int pw);
`ifdef WEIGHT_LOAD_CTRL_PERF_EN
    return ng * pw;
`else
    return 0 * ng * pw;
`endif
  endfunction

  function automatic int addr_errors(input logic [31:0] base);
    int e = 0;
    for (int i = 0; i < gaddr.size(); i++)
      if (gaddr[i] !== base + 32'(8 * i)) e++;
    return e;
  endfunction

  function automatic int bad_runs();
    int e = 0;
    foreach (of_runs[i]) if (of_runs[i] != 13) e++;
    return e;
  endfunction

  // Drives one job with a behavioural weight buffer / PE array and records what the DUT does
  task automatic run_job(input logic [1:0] m, input logic [31:0] base, input int ng,
                         input int gnt_pat, input int pe_wait, input int abort_beat);
    int got = 0, rdy_cnt = 0, cur_run = 0;
    int bt = beats_of(m);
    bit in_out = 0, pe_go = 0, seen_done = 0, abort_done = 0;
    gaddr.delete(); of_runs.delete();
    n_grant = 0; n_free = 0; n_done = 0; done_cyc = -1; free_cyc = -1; abort_cyc = -1;
    early_of = 0; req_after_abort = 0; busy_gap = 0; mode_bad = 0; req_cycles = 0;
    busy_after = 0; groups_at_free = 8'hxx; groups_after_start = 8'hxx; timeout = 0;
    for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
      @(negedge clk);
      start_i      = (cyc == 0 || cyc == 3);
      mode_in_i    = (cyc == 3) ? ~m : m;
      base_addr_i  = (cyc == 3) ? ~base : base;
      num_groups_i = (cyc == 3) ? 8'd0 : 8'(ng);
      wb_mem_req_i = (got < bt);
      wb_ready_i   = (got >= bt);
      case (gnt_pat)
        0:       mem_rd_gnt_i = 1'b1;
        1:       mem_rd_gnt_i = (cyc % 2 == 1);
        default: mem_rd_gnt_i = 1'($urandom_range(0, 1));
      endcase
      if (in_out)          pe_ready_i = 1'($urandom_range(0, 1));
      else if (wb_ready_i) pe_ready_i = (rdy_cnt > pe_wait);
      else                 pe_ready_i = 1'b0;
      if (wb_ready_i) rdy_cnt++;
      abort_i = (abort_beat > 0 && !abort_done && n_grant == abort_beat - 1 && got < bt);
      if (abort_i) begin abort_done = 1; abort_cyc = cyc; end
      #1;
      if (mem_rd_req_o) req_cycles++;
      if (abort_done && cyc > abort_cyc && mem_rd_req_o) req_after_abort++;
      if (mem_rd_req_o && mem_rd_gnt_i) begin
        gaddr.push_back(mem_rd_addr_o); got++; n_grant++;
      end
      if (cyc == 1) groups_after_start = groups_left_o;
      if (cyc >= 1 && wb_mode_o !== m) mode_bad++;
      if (cyc >= 1 && !done_o && busy_o !== 1'b1) busy_gap++;
      if (wb_output_filter_o && !pe_go) early_of++;
      if (wb_ready_i && pe_ready_i) pe_go = 1;
      if (wb_output_filter_o) begin
        cur_run++; in_out = 1;
      end else if (cur_run > 0) begin
        of_runs.push_back(cur_run); cur_run = 0;
      end
      if (wb_free_o) begin
        n_free++;
        if (n_free == 1) begin free_cyc = cyc; groups_at_free = groups_left_o; end
        got = 0; rdy_cnt = 0; in_out = 0; pe_go = 0;
      end
      if (done_o) begin
        n_done++; done_cyc = cyc; busy_at_done = busy_o; seen_done = 1;
      end
    end
    if (!seen_done) timeout = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start_i = 0; abort_i = 0; wb_mem_req_i = 0; wb_ready_i = 0; pe_ready_i = 0;
      #1;
      if (done_o) n_done++;
      if (wb_free_o) n_free++;
      if (mem_rd_req_o) req_cycles++;
      if (busy_o) busy_after++;
    end
    stall_end = stall_cycles_o;
  endtask

  task automatic test_reset();
    rst_n = 0; start_i = 0; mode_in_i = 2'd3; base_addr_i = 32'h1234_5678; num_groups_i = 8'd5;
    abort_i = 0; mem_rd_gnt_i = 1; wb_mem_req_i = 1; wb_ready_i = 1; pe_ready_i = 1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (mem_rd_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got %0b exp 0", mem_rd_req_o); end
    total++; if (mem_rd_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got %0h exp 0", mem_rd_addr_o); end
    total++; if (wb_mode_o !== 2'd0) begin bad++; $display("FAIL reset_mode got %0d exp 0", wb_mode_o); end
    total++; if ({wb_output_filter_o, wb_free_o, busy_o, done_o} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got %b exp 0000", {wb_output_filter_o, wb_free_o, busy_o, done_o}); end
    total++; if (groups_left_o !== 8'd0) begin bad++; $display("FAIL reset_groups got %0d exp 0", groups_left_o); end
    total++; if (stall_cycles_o !== 16'd0) begin bad++; $display("FAIL reset_stall got %0d exp 0", stall_cycles_o); end
    @(negedge clk);
    rst_n = 1; wb_mem_req_i = 0; wb_ready_i = 0; pe_ready_i = 0;
  endtask

  task automatic test_mode3_single();
    run_job(2'd2, 32'h1000, 1, 0, 0, 0);
    total++; if (timeout) begin bad++; $display("FAIL m3_timeout got no done exp done"); end
    total++; if (n_grant != 20) begin bad++; $display("FAIL m3_grants got %0d exp 20", n_grant); end
    total++; if (n_grant == 20 && gaddr[19] !== 32'h1098) begin bad++; $display("FAIL m3_last_addr got %0h exp 1098", gaddr[19]); end
    total++; if (addr_errors(32'h1000) != 0) begin bad++; $display("FAIL m3_addr_seq got %0d bad exp 0", addr_errors(32'h1000)); end
    total++; if (of_runs.size() != 1 || bad_runs() != 0) begin bad++; $display("FAIL m3_of_hold got %0d runs/%0d bad exp 1/0", of_runs.size(), bad_runs()); end
    total++; if (n_free != 1 || n_done != 1) begin bad++; $display("FAIL m3_pulses got free=%0d done=%0d exp 1/1", n_free, n_done); end
    total++; if (!(free_cyc >= 0 && done_cyc > free_cyc)) begin bad++; $display("FAIL m3_order got free@%0d done@%0d exp free first", free_cyc, done_cyc); end
    total++; if (busy_at_done !== 1'b0 || busy_after != 0 || busy_gap != 0) begin
      bad++; $display("FAIL m3_busy got done=%0b after=%0d gap=%0d exp 0/0/0", busy_at_done, busy_after, busy_gap); end
    total++; if (mode_bad != 0 || groups_after_start !== 8'd1) begin
      bad++; $display("FAIL m3_latch got mode_bad=%0d groups=%0d exp 0/1", mode_bad, groups_after_start); end
  endtask

  task automatic test_mode1_two_groups();
    logic [31:0] base = {$urandom_range(0, 32'h0FFF_FFFF), 3'b000} & 32'h7FFF_FFF8;
    run_job(2'd0, base, 2, 1, 0, 0);
    total++; if (n_grant != 176 || timeout) begin bad++; $display("FAIL m1_grants got %0d exp 176", n_grant); end
    total++; if (n_grant == 176 && gaddr[88] !== base + 32'd704) begin bad++; $display("FAIL m1_group2_addr got %0h exp %0h", gaddr[88], base + 32'd704); end
    total++; if (addr_errors(base) != 0) begin bad++; $display("FAIL m1_addr_seq got %0d bad exp 0", addr_errors(base)); end
    total++; if (n_free != 2 || n_done != 1) begin bad++; $display("FAIL m1_pulses got free=%0d done=%0d exp 2/1", n_free, n_done); end
    total++; if (of_runs.size() != 2 || bad_runs() != 0) begin bad++; $display("FAIL m1_of_hold got %0d runs/%0d bad exp 2/0", of_runs.size(), bad_runs()); end
    total++; if (groups_after_start !== 8'd2 || mode_bad != 0) begin bad++; $display("FAIL m1_latch got groups=%0d mode_bad=%0d exp 2/0", groups_after_start, mode_bad); end
  endtask

  task automatic test_pe_wait();
    run_job(2'd3, 32'h0000_0200, 1, 0, 10, 0);
    total++; if (n_grant != 12 || timeout) begin bad++; $display("FAIL pe_grants got %0d exp 12", n_grant); end
    total++; if (early_of != 0) begin bad++; $display("FAIL pe_early_output got %0d cycles exp 0", early_of); end
    total++; if (of_runs.size() != 1 || bad_runs() != 0) begin bad++; $display("FAIL pe_of_hold got %0d runs exp 1", of_runs.size()); end
    total++; if (stall_end !== 16'(exp_stall(1, 10))) begin bad++; $display("FAIL pe_stall got %0d exp %0d", stall_end, exp_stall(1, 10)); end
  endtask

  task automatic test_zero_groups();
    run_job(2'd1, 32'h8000, 0, 0, 0, 0);
    total++; if (done_cyc != 2) begin bad++; $display("FAIL zero_done_cycle got %0d exp 2", done_cyc); end
    total++; if (req_cycles != 0 || n_free != 0) begin bad++; $display("FAIL zero_activity got req=%0d free=%0d exp 0/0", req_cycles, n_free); end
    total++; if (n_done != 1 || busy_after != 0) begin bad++; $display("FAIL zero_done_count got %0d busy_after=%0d exp 1/0", n_done, busy_after); end
  endtask

  task automatic test_abort();
    run_job(2'd1, 32'h0004_0000, 3, 0, 0, 30);
    total++; if (n_grant != 30) begin bad++; $display("FAIL abort_grants got %0d exp 30", n_grant); end
    total++; if (req_after_abort != 0) begin bad++; $display("FAIL abort_req_after got %0d exp 0", req_after_abort); end
    total++; if (abort_cyc < 0 || free_cyc != abort_cyc + 1) begin bad++; $display("FAIL abort_free_cycle got %0d exp %0d", free_cyc, abort_cyc + 1); end
    total++; if (groups_at_free !== 8'd0) begin bad++; $display("FAIL abort_groups got %0d exp 0", groups_at_free); end
    total++; if (n_free != 1 || n_done != 1 || done_cyc <= free_cyc) begin
      bad++; $display("FAIL abort_pulses got free=%0d done=%0d@%0d exp 1/1 after free", n_free, n_done, done_cyc); end
    total++; if (of_runs.size() != 0) begin bad++; $display("FAIL abort_output got %0d runs exp 0", of_runs.size()); end
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 4; j++) begin
      logic [1:0]  m  = 2'($urandom_range(0, 3));
      int          ng = $urandom_range(1, 3);
      int          pw = $urandom_range(0, 4);
      logic [31:0] base = $urandom;
      base[2:0] = 3'b000;
      if (j == 0) base = 32'hFFFF_FF80;
      run_job(m, base, ng, 2, pw, 0);
      total++; if (n_grant != ng * beats_of(m) || timeout) begin bad++; $display("FAIL rnd%0d_grants got %0d exp %0d", j, n_grant, ng * beats_of(m)); end
      total++; if (addr_errors(base) != 0) begin bad++; $display("FAIL rnd%0d_addr_seq got %0d bad exp 0", j, addr_errors(base)); end
      total++; if (n_free != ng || n_done != 1) begin bad++; $display("FAIL rnd%0d_pulses got free=%0d done=%0d exp %0d/1", j, n_free, n_done, ng); end
      total++; if (of_runs.size() != ng || bad_runs() != 0 || early_of != 0) begin
        bad++; $display("FAIL rnd%0d_output got runs=%0d bad=%0d early=%0d exp %0d/0/0", j, of_runs.size(), bad_runs(), early_of, ng); end
      total++; if (stall_end !== 16'(exp_stall(ng, pw))) begin bad++; $display("FAIL rnd%0d_stall got %0d exp %0d", j, stall_end, exp_stall(ng, pw)); end
      total++; if (mode_bad != 0 || busy_gap != 0) begin bad++; $display("FAIL rnd%0d_mode_busy got %0d/%0d exp 0/0", j, mode_bad, busy_gap); end
    end
  endtask

  task automatic test_reset_mid();
    int got = 0, ofc = 0;
    bit reached = 0;
    for (int c = 0; c < 500 && !reached; c++) begin
      @(negedge clk);
      start_i = (c == 0); mode_in_i = 2'd3; base_addr_i = 32'h0000_3000; num_groups_i = 8'd2;
      abort_i = 0; mem_rd_gnt_i = 1; wb_mem_req_i = (got < 12); wb_ready_i = (got >= 12); pe_ready_i = 1;
      #1;
      if (mem_rd_req_o && mem_rd_gnt_i) got++;
      if (wb_output_filter_o) ofc++;
      if (ofc == 4) reached = 1;
    end
    total++; if (!reached) begin bad++; $display("FAIL rstmid_reach_output got none exp output"); end
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    #1;
    total++; if ({mem_rd_req_o, wb_output_filter_o, wb_free_o, busy_o, done_o} !== 5'b0) begin
      bad++; $display("FAIL rstmid_flags got %b exp 00000", {mem_rd_req_o, wb_output_filter_o, wb_free_o, busy_o, done_o}); end
    total++; if (mem_rd_addr_o !== 32'h0 || wb_mode_o !== 2'd0 || groups_left_o !== 8'd0 || stall_cycles_o !== 16'd0) begin
      bad++; $display("FAIL rstmid_values got addr=%0h mode=%0d groups=%0d stall=%0d exp 0", mem_rd_addr_o, wb_mode_o, groups_left_o, stall_cycles_o); end
    @(negedge clk);
    rst_n = 1;
    run_job(2'd2, 32'h40, 1, 0, 0, 0);
    total++; if (n_grant != 20 || gaddr.size() == 0 || gaddr[0] !== 32'h40) begin bad++; $display("FAIL rstmid_clean_grants got %0d exp 20", n_grant); end
    total++; if (n_done != 1 || n_free != 1 || of_runs.size() != 1 || bad_runs() != 0) begin
      bad++; $display("FAIL rstmid_clean_job got done=%0d free=%0d runs=%0d exp 1/1/1", n_done, n_free, of_runs.size()); end
  endtask

  initial begin
    test_reset();
    test_mode3_single();
    test_mode1_two_groups();
    test_pe_wait();
    test_zero_groups();
    test_abort();
    test_random_jobs();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
